// File: rtl/snes_multipad_if.sv
// Bus between the multipad reader and its user: control requests, pad wiring
// and the per-frame snapshot.
interface snes_multipad_if #(
  parameter int NUM_PADS = 2,
  parameter int BITS     = 16
);
  logic                     enable;
  logic                     poll_now;
  logic [NUM_PADS-1:0]      pad_data;
  logic                     pad_latch;
  logic                     pad_clk;
  logic [NUM_PADS*BITS-1:0] buttons;
  logic [NUM_PADS*BITS-1:0] pressed;
  logic [NUM_PADS-1:0]      connected;
  logic                     valid;
  logic                     busy;

  modport master (
    output enable, poll_now, pad_data,
    input  pad_latch, pad_clk, buttons, pressed, connected, valid, busy
  );

  modport slave (
    input  enable, poll_now, pad_data,
    output pad_latch, pad_clk, buttons, pressed, connected, valid, busy
  );
endinterface

// File: rtl/snes_multipad_reader.sv
// Multi-port SNES pad reader: one shared latch/clock pair, NUM_PADS serial lines
// captured in parallel, committed as one atomic snapshot per frame.
module snes_multipad_reader #(
  parameter int NUM_PADS      = 2,
  parameter int BITS          = 16,
  parameter int CLKS_PER_HALF = 300,
  parameter int POLL_CYCLES   = 833333
) (
  input  logic            clk,
  input  logic            rst,
  snes_multipad_if.slave  bus
);

  localparam int CW = $clog2(2*CLKS_PER_HALF);
  localparam int KW = ($clog2(BITS) > 0) ? $clog2(BITS) : 1;
  localparam int TW = $clog2(POLL_CYCLES + 1);

  localparam logic [CW-1:0] LATCH_LAST = CW'(2*CLKS_PER_HALF - 1);
  localparam logic [CW-1:0] HALF_LAST  = CW'(CLKS_PER_HALF - 1);
  localparam logic [KW-1:0] K_LAST     = KW'(BITS - 1);
  localparam logic [TW-1:0] T_LAST     = TW'(POLL_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, LATCH, CLK_LO, CLK_HI, DONE} state_t;

  state_t                          state, state_n;
  logic [CW-1:0]                   cnt, cnt_n;
  logic [KW-1:0]                   k, k_n;
  logic [TW-1:0]                   timer;
  logic                            pending;
  logic                            start, shift_en, commit;

  logic [NUM_PADS-1:0]             sync1, sync2;
  logic [NUM_PADS-1:0][BITS-1:0]   sr;
  logic [NUM_PADS-1:0][BITS-1:0]   new_buttons;
  logic [NUM_PADS-1:0]             new_conn;

  logic [NUM_PADS-1:0][BITS-1:0]   buttons_q, pressed_q;
  logic [NUM_PADS-1:0]             connected_q;
  logic                            valid_q, busy_q, latch_q, pclk_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      k     <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      k     <= k_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt + 1'b1;
    k_n      = k;
    start    = 1'b0;
    shift_en = 1'b0;
    commit   = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if ((bus.enable && timer == T_LAST) || bus.poll_now || pending) begin
          state_n = LATCH;
          start   = 1'b1;
        end
      end
      LATCH: begin
        if (cnt == LATCH_LAST) begin
          shift_en = 1'b1;
          state_n  = CLK_LO;
          cnt_n    = '0;
          k_n      = '0;
        end
      end
      CLK_LO: begin
        if (cnt == HALF_LAST) begin
          state_n = CLK_HI;
          cnt_n   = '0;
        end
      end
      CLK_HI: begin
        if (cnt == HALF_LAST) begin
          cnt_n = '0;
          // The final sample is the presence bit: it is consumed live by the
          // commit rather than shifted, so sr holds exactly the button bits.
          if (k == K_LAST) begin
            commit  = 1'b1;
            state_n = DONE;
          end else begin
            shift_en = 1'b1;
            k_n      = k + 1'b1;
            state_n  = CLK_LO;
          end
        end
      end
      DONE: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
      default: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  // Pads pull up to 1 when absent and drive 0 after their last bit.
  always_comb begin
    new_buttons = '0;
    new_conn    = '0;
    for (int unsigned p = 0; p < NUM_PADS; p++) begin
      new_conn[p]    = ~sync2[p];
      new_buttons[p] = sync2[p] ? '0 : ~sr[p];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1       <= '1;
      sync2       <= '1;
      sr          <= '0;
      timer       <= '0;
      pending     <= 1'b0;
      latch_q     <= 1'b0;
      pclk_q      <= 1'b1;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      buttons_q   <= '0;
      pressed_q   <= '0;
      connected_q <= '0;
    end else begin
      sync1 <= bus.pad_data;
      sync2 <= sync1;

      if (!bus.enable || start)
        timer <= '0;
      else if (timer != T_LAST)
        timer <= timer + 1'b1;

      if (start)
        pending <= 1'b0;
      else if (bus.poll_now && state != IDLE)
        pending <= 1'b1;

      if (shift_en)
        for (int unsigned p = 0; p < NUM_PADS; p++)
          sr[p] <= {sync2[p], sr[p][BITS-1:1]};

      // Strobes follow the next state so they are registered yet aligned with it.
      latch_q <= (state_n == LATCH);
      pclk_q  <= (state_n != CLK_LO);
      busy_q  <= (state_n != IDLE);
      valid_q <= commit;

      if (commit) begin
        buttons_q   <= new_buttons;
        pressed_q   <= new_buttons & ~buttons_q;
        connected_q <= new_conn;
      end else begin
        pressed_q   <= '0;
      end
    end
  end

  assign bus.pad_latch = latch_q;
  assign bus.pad_clk   = pclk_q;
  assign bus.buttons   = buttons_q;
  assign bus.pressed   = pressed_q;
  assign bus.connected = connected_q;
  assign bus.valid     = valid_q;
  assign bus.busy      = busy_q;

endmodule
